// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the in-order writeback pipe and a 2-entry buffer of multiply/divide results.
// The pipe normally wins. A buffered MDU result is forced out when the buffer
// is full, when it has waited STARVE_LIMIT cycles, or when the pipe is about
// to write a register that a buffered result also targets.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_dst,
    input  logic [63:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dst,
    input  logic [63:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        busy
);

    // starve_cnt is 3 bits wide, so the limit is taken modulo 8
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    // Buffer state: one valid bit per slot, 1-bit pointers (depth is 2)
    logic [FIFO_DEPTH-1:0] valid_reg;
    logic [FIFO_DEPTH-1:0] valid_next;
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic [2:0]            starve_cnt_reg;
    logic [2:0]            starve_cnt_next;
    logic [4:0]            dst_mem  [FIFO_DEPTH];
    logic [63:0]           data_mem [FIFO_DEPTH];

    logic                  full;
    logic                  empty;
    logic                  pipe_req;
    logic                  head_req;
    logic [FIFO_DEPTH-1:0] waw_hit;
    logic                  waw;
    logic                  forced;
    logic                  grant_head;
    logic                  grant_pipe;
    logic                  enq;
    logic [4:0]            head_dst;
    logic [63:0]           head_data;

    assign full      = &valid_reg;
    assign empty     = ~|valid_reg;
    assign head_dst  = dst_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    // While reset is held every request and handshake is masked off, so the
    // outputs read as idle no matter what the inputs or stale state say.
    assign pipe_req  = !reset && pipe_valid && pipe_wen;
    assign head_req  = !reset && !empty;
    assign mdu_ready = !reset && !full;
    assign busy      = !reset && !empty;
    assign enq       = mdu_valid && mdu_ready;

    // Per-slot hazard compare against the pipe destination
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_waw
            assign waw_hit[gi] = valid_reg[gi] && (dst_mem[gi] == pipe_dst);
        end
    endgenerate

    assign waw = pipe_req && (pipe_dst != 5'd0) && (|waw_hit);

    // Grant selection: forced drain beats the pipe, the pipe beats an idle head
    always_comb begin
        forced     = head_req && (full || (starve_cnt_reg == STARVE_MAX) || waw);
        grant_head = forced || (head_req && !pipe_req);
        grant_pipe = pipe_req && !grant_head;
        pipe_stall = pipe_req && grant_head;
    end

    // Register-file write port mux; r0 writes are consumed but not enabled
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 64'd0;
        if (grant_head) begin
            rf_wen   = (head_dst != 5'd0);
            rf_waddr = head_dst;
            rf_wdata = head_data;
        end else if (grant_pipe) begin
            rf_wen   = (pipe_dst != 5'd0);
            rf_waddr = pipe_dst;
            rf_wdata = pipe_data;
        end
    end

    // Next slot occupancy; enqueue and pop never target the same slot because
    // that would require the buffer to be both empty and full.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_valid
            assign valid_next[gi] = (enq && (wr_ptr_reg == 1'(gi))) ? 1'b1 :
                                    (grant_head && (rd_ptr_reg == 1'(gi))) ? 1'b0 :
                                    valid_reg[gi];
        end
    endgenerate

    // Starvation count follows the current head and restarts on every pop
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (empty || grant_head) begin
            starve_cnt_next = 3'd0;
        end else if (head_req && grant_pipe && (starve_cnt_reg < STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 3'd1;
        end
    end

    // Control state: occupancy, pointers and starvation count
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg      <= '0;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            starve_cnt_reg <= 3'd0;
        end else begin
            valid_reg      <= valid_next;
            rd_ptr_reg     <= rd_ptr_reg ^ grant_head;
            wr_ptr_reg     <= wr_ptr_reg ^ enq;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Entry payload storage; contents are only meaningful under a valid bit
    always_ff @(posedge clk) begin
        if (enq) begin
            dst_mem[wr_ptr_reg]  <= mdu_dst;
            data_mem[wr_ptr_reg] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a cycle-by-cycle vector table followed
// by a hand-written starvation sequence and a discarded-entry watch.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic        pipe_wen;
    logic [4:0]  pipe_dst;
    logic [63:0] pipe_data;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_dst;
    logic [63:0] mdu_data;
    logic        mdu_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        busy;

    int n_total;
    int n_pass;
    int ghost_cnt;
    logic watch_ghost;

    wb_port_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_wen   (pipe_wen),
        .pipe_dst   (pipe_dst),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .mdu_valid  (mdu_valid),
        .mdu_dst    (mdu_dst),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        pv;
        logic        pw;
        logic [4:0]  pd;
        logic [63:0] pdata;
        logic        mv;
        logic [4:0]  md;
        logic [63:0] mdata;
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        stall;
        logic        ready;
        logic        bsy;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rst, input logic pv, input logic pw, input logic [4:0] pd,
        input logic [63:0] pdata, input logic mv, input logic [4:0] md,
        input logic [63:0] mdata, input logic wen, input logic [4:0] waddr,
        input logic [63:0] wdata, input logic stall, input logic ready,
        input logic bsy);
        vec_t v;
        v.rst = rst; v.pv = pv; v.pw = pw; v.pd = pd; v.pdata = pdata;
        v.mv = mv; v.md = md; v.mdata = mdata; v.wen = wen; v.waddr = waddr;
        v.wdata = wdata; v.stall = stall; v.ready = ready; v.bsy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v);
        reset      = v.rst;
        pipe_valid = v.pv;
        pipe_wen   = v.pw;
        pipe_dst   = v.pd;
        pipe_data  = v.pdata;
        mdu_valid  = v.mv;
        mdu_dst    = v.md;
        mdu_data   = v.mdata;
    endtask

    // Drive one cycle just after the rising edge, compare at the falling edge
    task automatic run_cycle(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        apply(v);
        @(negedge clk);
        $display("%s: rst=%0d pipe(v=%0d w=%0d d=%0d) mdu(v=%0d d=%0d) -> wen=%0d waddr=%0d wdata=0x%0h stall=%0d ready=%0d busy=%0d",
                 tag, v.rst, v.pv, v.pw, v.pd, v.mv, v.md,
                 rf_wen, rf_waddr, rf_wdata, pipe_stall, mdu_ready, busy);
        check({tag, " rf_wen"},     64'(rf_wen),     64'(v.wen));
        check({tag, " rf_waddr"},   64'(rf_waddr),   64'(v.waddr));
        check({tag, " rf_wdata"},   rf_wdata,        v.wdata);
        check({tag, " pipe_stall"}, 64'(pipe_stall), 64'(v.stall));
        check({tag, " mdu_ready"},  64'(mdu_ready),  64'(v.ready));
        check({tag, " busy"},       64'(busy),       64'(v.bsy));
    endtask

    // Entries for r4/r5 are buffered when reset hits; they must never be written
    always @(negedge clk) begin
        if (watch_ghost && rf_wen && (rf_waddr == 5'd4 || rf_waddr == 5'd5))
            ghost_cnt++;
    end

    initial begin
        vec_t v;
        n_total     = 0;
        n_pass      = 0;
        ghost_cnt   = 0;
        watch_ghost = 1'b0;
        reset       = 1'b1;
        pipe_valid  = 1'b0;
        pipe_wen    = 1'b0;
        pipe_dst    = 5'd0;
        pipe_data   = 64'd0;
        mdu_valid   = 1'b0;
        mdu_dst     = 5'd0;
        mdu_data    = 64'd0;

        //             rst pv pw pd     pdata     mv md     mdata      wen waddr  wdata     st rdy bsy
        // reset held with active inputs: everything idle
        vecs[0]  = mk(1, 1, 1, 5'd5,  64'h11,  1, 5'd7,  64'hAA,   0, 5'd0,  64'h0,    0, 0, 0);
        // pipe-only write, first cycle after reset
        vecs[1]  = mk(0, 1, 1, 5'd5,  64'h11,  0, 5'd0,  64'h0,    1, 5'd5,  64'h11,   0, 1, 0);
        // MDU idle drain: accept, write next cycle, then empty
        vecs[2]  = mk(0, 0, 0, 5'd0,  64'h0,   1, 5'd7,  64'hAA,   0, 5'd0,  64'h0,    0, 1, 0);
        vecs[3]  = mk(0, 0, 0, 5'd0,  64'h0,   0, 5'd0,  64'h0,    1, 5'd7,  64'hAA,   0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 5'd0,  64'h0,   0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 1, 0);
        // valid instruction without a write never stalls or writes
        vecs[5]  = mk(0, 1, 0, 5'd4,  64'h55,  0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 1, 0);
        // pipe write to r0: consumed, no enable; MDU r12 accepted meanwhile
        vecs[6]  = mk(0, 1, 1, 5'd0,  64'h77,  1, 5'd12, 64'hC0,   0, 5'd0,  64'h77,   0, 1, 0);
        // WAW guard: buffered r12 goes first, pipe r12 next cycle
        vecs[7]  = mk(0, 1, 1, 5'd12, 64'hD0,  0, 5'd0,  64'h0,    1, 5'd12, 64'hC0,   1, 1, 1);
        vecs[8]  = mk(0, 1, 1, 5'd12, 64'hD0,  0, 5'd0,  64'h0,    1, 5'd12, 64'hD0,   0, 1, 0);
        // fill the buffer while the pipe keeps writing
        vecs[9]  = mk(0, 0, 0, 5'd0,  64'h0,   1, 5'd1,  64'h101,  0, 5'd0,  64'h0,    0, 1, 0);
        vecs[10] = mk(0, 1, 1, 5'd20, 64'h200, 1, 5'd2,  64'h102,  1, 5'd20, 64'h200,  0, 1, 1);
        // full: no ready, head forced out over the pipe
        vecs[11] = mk(0, 1, 1, 5'd20, 64'h200, 1, 5'd3,  64'h103,  1, 5'd1,  64'h101,  1, 0, 1);
        vecs[12] = mk(0, 1, 1, 5'd20, 64'h200, 1, 5'd3,  64'h103,  1, 5'd20, 64'h200,  0, 1, 1);
        // full with pipe idle: head drains, no stall
        vecs[13] = mk(0, 0, 0, 5'd0,  64'h0,   0, 5'd0,  64'h0,    1, 5'd2,  64'h102,  0, 0, 1);
        // simultaneous pop and enqueue keeps one entry
        vecs[14] = mk(0, 0, 0, 5'd0,  64'h0,   1, 5'd4,  64'h104,  1, 5'd3,  64'h103,  0, 1, 1);
        vecs[15] = mk(0, 1, 1, 5'd21, 64'h300, 1, 5'd5,  64'h105,  1, 5'd21, 64'h300,  0, 1, 1);
        // reset with r4/r5 buffered: discarded
        vecs[16] = mk(1, 1, 1, 5'd4,  64'h999, 1, 5'd6,  64'h106,  0, 5'd0,  64'h0,    0, 0, 0);
        vecs[17] = mk(0, 0, 0, 5'd0,  64'h0,   0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 1, 0);
        vecs[18] = mk(0, 0, 0, 5'd0,  64'h0,   0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 1, 0);

        // one reset edge before the table starts
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            if (i == 16) watch_ghost = 1'b1;
            run_cycle($sformatf("row%0d", i), vecs[i]);
        end

        // Starvation: one buffered r3, continuous pipe r9 requests
        v = mk(0, 0, 0, 5'd0, 64'h0, 1, 5'd3, 64'h33, 0, 5'd0, 64'h0, 0, 1, 0);
        run_cycle("starve0", v);
        for (int c = 1; c <= 6; c++) begin
            if (c == 5)
                v = mk(0, 1, 1, 5'd9, 64'h99, 0, 5'd0, 64'h0, 1, 5'd3, 64'h33, 1, 1, 1);
            else if (c == 6)
                v = mk(0, 1, 1, 5'd9, 64'h99, 0, 5'd0, 64'h0, 1, 5'd9, 64'h99, 0, 1, 0);
            else
                v = mk(0, 1, 1, 5'd9, 64'h99, 0, 5'd0, 64'h0, 1, 5'd9, 64'h99, 0, 1, 1);
            run_cycle($sformatf("starve%0d", c), v);
        end

        // a few idle cycles, then confirm the discarded entries never appeared
        v = mk(0, 0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 1, 0);
        run_cycle("idle_end", v);
        check("discarded_writes", 64'(ghost_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive blocked cycles of a buffered MDU result that forces it to drain.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2 (fixed at 2): the number of MDU result buffer entries.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- pipe_valid  in  1  writeback-stage instruction present (not a bubble).
- pipe_wen  in  1  the instruction writes the register file.
- pipe_dst  in  5  destination register index.
- pipe_data  in  64  writeback result.
- pipe_stall  out  1  the writeback write is not performed this cycle; upstream holds all pipe_* inputs stable.
- mdu_valid  in  1  multiply/divide result offered.
- mdu_dst  in  5  MDU destination register index.
- mdu_data  in  64  MDU result.
- mdu_ready  out  1  MDU result accepted when mdu_valid && mdu_ready.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  64  register-file write data.
- busy  out  1  the FIFO is not empty.

Function
REQ-005 MDU results SHALL enter a 2-entry in-order FIFO on each cycle with mdu_valid && mdu_ready; mdu_ready SHALL equal !full, computed from registered state only.
REQ-006 When full, the FIFO SHALL accept no enqueue even in a cycle where it dequeues; no combinational ready-through is allowed.
REQ-007 The earliest register-file write of an MDU result SHALL be the cycle after acceptance; there is no bypass path.
REQ-008 A pipe request SHALL exist when pipe_valid && pipe_wen; a head request SHALL exist when the FIFO is not empty.
REQ-009 A forced drain SHALL occur when a head request exists and any of the following holds:
- the FIFO is full;
- starve_cnt == STARVE_LIMIT;
- the pipe request has pipe_dst != 0 and pipe_dst equals the dst of any valid FIFO entry (WAW guard).
REQ-010 Grant SHALL follow these rules:
- a forced drain grants the head and asserts pipe_stall if a pipe request exists;
- otherwise a pipe request is granted and pipe_stall=0;
- otherwise a head request is granted.
REQ-011 pipe_stall SHALL be asserted only when a pipe request exists and the grant goes to the head; pipe_valid && !pipe_wen SHALL never stall.
REQ-012 The granted source SHALL drive rf_waddr and rf_wdata combinationally; rf_wen=1 unless the granted dst==0.
REQ-013 A granted dst==0 write SHALL still be consumed: the FIFO pops, or the pipe is not stalled.
REQ-014 With no grant, the outputs SHALL be rf_wen=0, rf_waddr=0, rf_wdata=0.
REQ-015 The FIFO SHALL pop on every head grant; an enqueue and a pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-016 starve_cnt (3-bit) SHALL behave as follows:
- reset to 0 when the FIFO is empty or the head is granted;
- otherwise incremented when a head request loses to the pipe;
- saturates at STARVE_LIMIT.
REQ-017 starve_cnt SHALL track the current head; a pop SHALL clear it so that the next head starts at 0.
REQ-018 busy SHALL equal FIFO not empty, from registered state.
REQ-019 All state (FIFO pointers, valid bits, entries, starve_cnt) SHALL update on the rising edge of clk.

Reset
REQ-020 When reset=1 at a clk edge, the FIFO SHALL become empty and starve_cnt SHALL become 0; entry data is don't-care.
REQ-021 While reset=1, the outputs SHALL be rf_wen=0, pipe_stall=0, mdu_ready=0, busy=0, rf_waddr=0, rf_wdata=0, regardless of inputs.
REQ-022 A reset asserted mid-operation SHALL discard buffered MDU results without writing them.
REQ-023 In the first cycle after reset, the block SHALL behave as empty, with mdu_ready=1.

Verification
REQ-024 A bench SHALL cover a pipe-only write: pipe_valid=1, pipe_wen=1, dst=5, data=0x11 with FIFO empty -> same cycle rf_wen=1, waddr=5, wdata=0x11, pipe_stall=0.
REQ-025 A bench SHALL cover an MDU idle drain: mdu_valid=1, dst=7, data=0xAA at cycle 0 with pipe idle -> cycle 1 rf_wen=1, waddr=7, wdata=0xAA, busy 1->0 at cycle 2.
REQ-026 A bench SHALL cover starvation: one MDU entry (dst=3) plus a continuous pipe request (dst=9) -> pipe granted 4 cycles; cycle 5 head granted with pipe_stall=1; pipe granted again in cycle 6.
REQ-027 A bench SHALL cover the WAW guard: FIFO holds dst=12, pipe request dst=12 -> pipe_stall=1, head writes x12 first, pipe x12 written next cycle.
REQ-028 A bench SHALL cover a full FIFO: 2 entries with mdu_valid held high -> mdu_ready=0; head forced out with pipe_stall=1 if pipe active; mdu_ready=1 the next cycle.
REQ-029 A bench SHALL cover dst zero plus reset: pipe dst=0 -> rf_wen=0, no stall; reset asserted with 2 entries -> next cycle busy=0, mdu_ready=1, and no write of the discarded entries ever appears.
